grid_tracker: RTL and testbench
===============================

Name: grid_tracker

Overview:
- Parametrised successor of the single-scale push-button paint tracker.
- Keeps a GRID_W x GRID_H bitmap of painted cells, moved by an edge-detected 4-direction cursor, with paint and erase pen modes, optional wrap-around and a sequenced clear.
- Maintains incremental painted-cell and pixel counts.
- Produces a pipelined per-pixel "on" and cursor-highlight flag for the VGA pixel path, with cell size and mirroring set by parameters.

Parameters:
GRID_W, 96, bitmap columns (>=2)
GRID_H, 54, bitmap rows (>=2)
CELL_W, 5, screen pixels per cell horizontally
CELL_H, 5, screen pixels per cell vertically
MIRROR_X, 1, 1: column index = GRID_W-1-(hcnt/CELL_W)
MIRROR_Y, 1, 1: row index = GRID_H-1-(vcnt/CELL_H)
CW, 12, width of hcnt/vcnt
PCNT_W, 24, width of pixel_cnt

Ports:
CLK  in  1  system clock, all logic on rising edge
RESET  in  1  asynchronous, active-low reset
btn  in  4  raw buttons: [0] right, [1] left, [2] up, [3] down
pen_en  in  1  level: write the cursor cell each idle cycle
erase  in  1  level: pen writes 0 instead of 1
wrap_en  in  1  1: cursor wraps at edges; 0: clamps
clear_req  in  1  pulse: start bitmap clear
pix_valid  in  1  hcnt/vcnt qualify a pixel
hcnt  in  CW  pixel x
vcnt  in  CW  pixel y
on  out  1  pixel lies in a painted cell
cur_hl  out  1  pixel lies in the cursor cell
on_valid  out  1  pix_valid delayed 2 cycles
cur_row  out  clog2(GRID_H)  cursor row
cur_col  out  clog2(GRID_W)  cursor column
cell_cnt  out  clog2(GRID_W*GRID_H+1)  painted cells
pixel_cnt  out  PCNT_W  cell_cnt*CELL_W*CELL_H, registered
busy  out  1  clear in progress

Behaviour:
- Reset (RESET=0, async):
  - cur_row, cur_col, cell_cnt, pixel_cnt, on, cur_hl and on_valid go to 0; button history goes to 0.
  - FSM enters CLEAR with busy=1.
  - The bitmap has no reset; it is cleared by the sweep.
- FSM states:
  - CLEAR: writes 0 to one cell per cycle in linear order row*GRID_W+col, from 0 to GRID_W*GRID_H-1, then goes to IDLE. The sweep takes exactly GRID_W*GRID_H cycles. cell_cnt is forced to 0 on entry.
  - IDLE: busy=0. clear_req=1 moves to CLEAR on the next edge. The cursor is not changed by a clear.
- While in CLEAR:
  - button edges, pen writes and clear_req are ignored and discarded, not queued;
  - on and cur_hl are forced to 0.
- Buttons:
  - A rising edge on btn[i] (btn registered once, edge = btn & ~btn_q) requests a one-cell move.
  - Simultaneous edges: priority right > left > up > down. Only one move per cycle; the lower-priority edges are dropped.
  - Up means row+1 and down means row-1. Right means col+1 and left means col-1.
- Edges:
  - wrap_en=1: GRID_W-1+1 gives 0, 0-1 gives GRID_W-1; same for rows.
  - wrap_en=0: the index saturates at 0 and GRID_W-1 (GRID_H-1 for rows).
- Pen:
  - In IDLE with pen_en=1, the cell at the current (pre-move) cursor is written with ~erase each cycle.
  - cell_cnt +1 only on a 0->1 write and -1 only on a 1->0 write. A move and a write in the same cycle are both applied: the write goes to the old position.
- pixel_cnt:
  - equals cell_cnt*CELL_W*CELL_H, one cycle after cell_cnt;
  - truncated to PCNT_W.
- Render pipeline, latency 2:
  - Stage 1 registers the cell indices (with mirroring applied) and in_range = pix_valid && hcnt<GRID_W*CELL_W && vcnt<GRID_H*CELL_H.
  - Stage 2 outputs on = in_range && bitmap[row][col], cur_hl = in_range && cell == cursor, and on_valid.
  - Out-of-range or invalid pixels give on=0 and cur_hl=0.
  - The bitmap read sees writes committed before the stage-2 edge.
- Reset mid-CLEAR restarts the sweep from cell 0.

Test Plan:
- Reset low 3 cycles then release, defaults -> busy=1 for exactly 5184 cycles, then 0; cell_cnt=0, pixel_cnt=0, cursor (0,0).
- pen_en=1, erase=0, 3 right edges spaced 4 cycles -> cells (0,0..3) set; cell_cnt=4, pixel_cnt=100; repainting the same cell leaves cell_cnt=4.
- wrap_en=0 with 1 down edge from row 0 -> cur_row=0. wrap_en=1 with the same edge -> cur_row=53. wrap_en=1 with right from col 95 -> col 0.
- Right and up edges in the same cycle -> only cur_col increments; cur_row unchanged. Holding btn high gives no further moves.
- After painting cell (53,95) with MIRROR=1, drive pix_valid, hcnt=2, vcnt=2 -> on=1, cur_hl per cursor, on_valid=1 two cycles later; hcnt=480 -> on=0.
- With cell_cnt=4, pulse clear_req -> busy asserts next cycle; btn edges during clear leave cursor unchanged; after the sweep cell_cnt=0 and all render reads give on=0.

Source files
------------

// File: rtl/grid_tracker.sv
// Paint-grid tracker: a cursor-driven GRID_W x GRID_H bitmap with pen/erase, a sequenced clear,
// incremental painted-cell/pixel counts, and a two-stage per-pixel render lookup for the video path.
//   state   | meaning
//   S_CLEAR | sweeping zeros through the bitmap, one cell per cycle; inputs discarded
//   S_IDLE  | cursor moves, pen writes and clear requests accepted
module grid_tracker #(
  parameter int GRID_W   = 96,
  parameter int GRID_H   = 54,
  parameter int CELL_W   = 5,
  parameter int CELL_H   = 5,
  parameter bit MIRROR_X = 1,
  parameter bit MIRROR_Y = 1,
  parameter int CW       = 12,
  parameter int PCNT_W   = 24,
  localparam int RW      = $clog2(GRID_H),
  localparam int CLW     = $clog2(GRID_W),
  localparam int NCELL   = GRID_W * GRID_H,
  localparam int AW      = $clog2(NCELL),
  localparam int CCW     = $clog2(NCELL + 1)
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [3:0]        btn,
  input  logic              pen_en,
  input  logic              erase,
  input  logic              wrap_en,
  input  logic              clear_req,
  input  logic              pix_valid,
  input  logic [CW-1:0]     hcnt,
  input  logic [CW-1:0]     vcnt,
  output logic              on,
  output logic              cur_hl,
  output logic              on_valid,
  output logic [RW-1:0]     cur_row,
  output logic [CLW-1:0]    cur_col,
  output logic [CCW-1:0]    cell_cnt,
  output logic [PCNT_W-1:0] pixel_cnt,
  output logic              busy
);

  typedef enum logic {S_CLEAR = 1'b0, S_IDLE = 1'b1} state_t;

  state_t             r_state, w_state_nxt;
  logic [3:0]         r_btn_q;
  logic [AW-1:0]      r_clr_left;
  logic [RW-1:0]      r_row, w_row_nxt;
  logic [CLW-1:0]     r_col, w_col_nxt;
  logic [CCW-1:0]     r_cnt;
  logic [PCNT_W-1:0]  r_pcnt;
  logic               r_bitmap [NCELL];
  logic [RW-1:0]      r_s1_row;
  logic [CLW-1:0]     r_s1_col;
  logic               r_s1_inr, r_s1_vld;
  logic               r_on, r_hl, r_ov;

  logic               w_idle;
  logic [3:0]         w_edge;
  logic [AW-1:0]      w_cur_addr, w_clr_addr, w_wr_addr, w_rd_addr;
  logic               w_wr_en, w_wr_data, w_old;
  logic [RW-1:0]      w_prow;
  logic [CLW-1:0]     w_pcol;
  logic               w_inr;

  assign w_idle     = (r_state == S_IDLE);
  assign w_edge     = btn & ~r_btn_q;
  assign w_cur_addr = AW'(r_row) * AW'(GRID_W) + AW'(r_col);
  // r_clr_left counts down to the terminal cell, so the sweep address runs upward from 0
  assign w_clr_addr = AW'(NCELL - 1) - r_clr_left;
  assign w_wr_en    = !w_idle || pen_en;
  assign w_wr_addr  = w_idle ? w_cur_addr : w_clr_addr;
  assign w_wr_data  = w_idle && !erase;
  assign w_old      = r_bitmap[w_cur_addr];

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_CLEAR: if (r_clr_left == '0) w_state_nxt = S_IDLE;
      S_IDLE:  if (clear_req) w_state_nxt = S_CLEAR;
      default: w_state_nxt = S_CLEAR;
    endcase
  end

  always_comb begin
    w_row_nxt = r_row;
    w_col_nxt = r_col;
    if (w_idle) begin
      if (w_edge[0]) begin
        if (r_col == CLW'(GRID_W - 1)) w_col_nxt = wrap_en ? '0 : r_col;
        else                           w_col_nxt = r_col + CLW'(1);
      end else if (w_edge[1]) begin
        if (r_col == '0) w_col_nxt = wrap_en ? CLW'(GRID_W - 1) : r_col;
        else             w_col_nxt = r_col - CLW'(1);
      end else if (w_edge[2]) begin
        if (r_row == RW'(GRID_H - 1)) w_row_nxt = wrap_en ? '0 : r_row;
        else                          w_row_nxt = r_row + RW'(1);
      end else if (w_edge[3]) begin
        if (r_row == '0) w_row_nxt = wrap_en ? RW'(GRID_H - 1) : r_row;
        else             w_row_nxt = r_row - RW'(1);
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_state    <= S_CLEAR;
      r_clr_left <= AW'(NCELL - 1);
      r_btn_q    <= '0;
      r_row      <= '0;
      r_col      <= '0;
      r_cnt      <= '0;
      r_pcnt     <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_btn_q <= btn;
      r_row   <= w_row_nxt;
      r_col   <= w_col_nxt;
      r_pcnt  <= PCNT_W'(32'(r_cnt) * 32'(CELL_W * CELL_H));
      if (w_idle) r_clr_left <= AW'(NCELL - 1);
      else        r_clr_left <= r_clr_left - AW'(1);
      if (!w_idle || clear_req)            r_cnt <= '0;
      else if (pen_en && !w_old && !erase) r_cnt <= r_cnt + CCW'(1);
      else if (pen_en && w_old && erase)   r_cnt <= r_cnt - CCW'(1);
    end
  end

  // No reset on the bitmap: the sweep that follows reset initialises it
  always_ff @(posedge CLK) begin
    if (w_wr_en) r_bitmap[w_wr_addr] <= w_wr_data;
  end

  assign w_pcol = MIRROR_X ? CLW'(GRID_W - 1) - CLW'(hcnt / CW'(CELL_W)) : CLW'(hcnt / CW'(CELL_W));
  assign w_prow = MIRROR_Y ? RW'(GRID_H - 1) - RW'(vcnt / CW'(CELL_H)) : RW'(vcnt / CW'(CELL_H));
  assign w_inr  = pix_valid && (hcnt < CW'(GRID_W * CELL_W)) && (vcnt < CW'(GRID_H * CELL_H));
  assign w_rd_addr = AW'(r_s1_row) * AW'(GRID_W) + AW'(r_s1_col);

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_s1_row <= '0;
      r_s1_col <= '0;
      r_s1_inr <= 1'b0;
      r_s1_vld <= 1'b0;
      r_on     <= 1'b0;
      r_hl     <= 1'b0;
      r_ov     <= 1'b0;
    end else begin
      r_s1_row <= w_prow;
      r_s1_col <= w_pcol;
      r_s1_inr <= w_inr;
      r_s1_vld <= pix_valid;
      r_on     <= w_idle && r_s1_inr && r_bitmap[w_rd_addr];
      r_hl     <= w_idle && r_s1_inr && (r_s1_row == r_row) && (r_s1_col == r_col);
      r_ov     <= r_s1_vld;
    end
  end

  assign on        = r_on;
  assign cur_hl    = r_hl;
  assign on_valid  = r_ov;
  assign cur_row   = r_row;
  assign cur_col   = r_col;
  assign cell_cnt  = r_cnt;
  assign pixel_cnt = r_pcnt;
  assign busy      = !w_idle;

endmodule

// File: tb/tb_grid_tracker.sv
// Randomised bench for grid_tracker: a grid/cursor reference model drives expectations, and render
// results are checked through a scoreboard queue popped whenever on_valid is presented.
module tb_grid_tracker;
  localparam int GW = 96, GH = 54, CWD = 5, CHT = 5, CW = 12, PW = 24;
  localparam bit MX = 1, MY = 1;
  localparam int N = GW * GH;

  logic          CLK = 1'b0, RESET = 1'b0;
  logic [3:0]    btn = '0;
  logic          pen_en = 1'b0, erase = 1'b0, wrap_en = 1'b0, clear_req = 1'b0, pix_valid = 1'b0;
  logic [CW-1:0] hcnt = '0, vcnt = '0;
  logic          on, cur_hl, on_valid, busy;
  logic [5:0]    cur_row;
  logic [6:0]    cur_col;
  logic [12:0]   cell_cnt;
  logic [PW-1:0] pixel_cnt;

  grid_tracker #(.GRID_W(GW), .GRID_H(GH), .CELL_W(CWD), .CELL_H(CHT), .MIRROR_X(MX), .MIRROR_Y(MY),
                 .CW(CW), .PCNT_W(PW)) dut (
    .CLK(CLK), .RESET(RESET), .btn(btn), .pen_en(pen_en), .erase(erase), .wrap_en(wrap_en),
    .clear_req(clear_req), .pix_valid(pix_valid), .hcnt(hcnt), .vcnt(vcnt), .on(on), .cur_hl(cur_hl),
    .on_valid(on_valid), .cur_row(cur_row), .cur_col(cur_col), .cell_cnt(cell_cnt),
    .pixel_cnt(pixel_cnt), .busy(busy));

  always #5 CLK = ~CLK;

  int errors = 0, checks = 0;
  bit bm [GH][GW];
  int mrow = 0, mcol = 0;

  typedef struct {bit on; bit hl; int h; int v;} exp_t;
  exp_t sb [$];

  task automatic chk(string name, longint act, longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int model_cnt();
    int s = 0;
    for (int r = 0; r < GH; r++) for (int c = 0; c < GW; c++) s += bm[r][c];
    return s;
  endfunction

  function automatic void model_clear();
    for (int r = 0; r < GH; r++) for (int c = 0; c < GW; c++) bm[r][c] = 1'b0;
  endfunction

  function automatic int step(int x, int d, int lim, bit w);
    int y = x + d;
    if (w) return (y % lim + lim) % lim;
    if (y < 0) return 0;
    if (y > lim - 1) return lim - 1;
    return y;
  endfunction

  // highest-priority edge wins: right, left, up, down
  function automatic void model_move(bit [3:0] e, bit w);
    if (e[0])      mcol = step(mcol, 1, GW, w);
    else if (e[1]) mcol = step(mcol, -1, GW, w);
    else if (e[2]) mrow = step(mrow, 1, GH, w);
    else if (e[3]) mrow = step(mrow, -1, GH, w);
  endfunction

  function automatic exp_t exp_px(int h, int v);
    exp_t e;
    int c, r;
    e.h = h; e.v = v; e.on = 1'b0; e.hl = 1'b0;
    if (h < GW * CWD && v < GH * CHT) begin
      c = MX ? GW - 1 - h / CWD : h / CWD;
      r = MY ? GH - 1 - v / CHT : v / CHT;
      e.on = bm[r][c];
      e.hl = (r == mrow) && (c == mcol);
    end
    return e;
  endfunction

  function automatic int hcoord(int c);
    return (MX ? GW - 1 - c : c) * CWD + int'($urandom_range(0, CWD - 1));
  endfunction

  function automatic int vcoord(int r);
    return (MY ? GH - 1 - r : r) * CHT + int'($urandom_range(0, CHT - 1));
  endfunction

  always @(negedge CLK) begin
    exp_t e;
    if (RESET && on_valid) begin
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL render_sb: on_valid=1 but no pixel expected (t=%0t)", $time);
      end else begin
        e = sb.pop_front();
        chk($sformatf("render_on h=%0d v=%0d", e.h, e.v), on, e.on);
        chk($sformatf("render_hl h=%0d v=%0d", e.h, e.v), cur_hl, e.hl);
      end
    end
  end

  task automatic check_state(string tag);
    int n = model_cnt();
    chk({tag, " cur_row"}, cur_row, mrow);
    chk({tag, " cur_col"}, cur_col, mcol);
    chk({tag, " cell_cnt"}, cell_cnt, n);
    chk({tag, " pixel_cnt"}, pixel_cnt, (n * CWD * CHT) % (1 << PW));
  endtask

  task automatic press(bit [3:0] v);
    @(negedge CLK); btn = v; model_move(v, wrap_en);
    @(negedge CLK); btn = '0;
    if (pen_en) bm[mrow][mcol] = !erase;
    @(negedge CLK);
    @(negedge CLK);
  endtask

  task automatic set_pen(bit p, bit e);
    @(negedge CLK); pen_en = p; erase = e;
    if (p) bm[mrow][mcol] = !e;
    @(negedge CLK);
    @(negedge CLK);
  endtask

  task automatic pix(int h, int v, bit pv);
    @(negedge CLK);
    pix_valid = pv; hcnt = CW'(h); vcnt = CW'(v);
    if (pv) sb.push_back(exp_px(h, v));
  endtask

  task automatic pix_drain();
    @(negedge CLK); pix_valid = 1'b0;
    repeat (3) @(negedge CLK);
  endtask

  task automatic render_batch(int n);
    int sel;
    for (int i = 0; i < n; i++) begin
      sel = int'($urandom_range(0, 3));
      case (sel)
        0: pix(hcoord(mcol), vcoord(mrow), 1'b1);
        1: pix(hcoord(int'($urandom_range(0, GW - 1))), vcoord(int'($urandom_range(0, GH - 1))), 1'b1);
        default: pix(int'($urandom_range(0, 600)), int'($urandom_range(0, 350)), $urandom_range(0, 7) != 0);
      endcase
    end
    pix_drain();
  endtask

  // counts cycles until busy drops; optionally pokes a button and pixels mid-sweep
  task automatic sweep(output int n, input bit poke);
    n = 0;
    while (busy && n < 20000) begin
      if (poke) begin
        if (n == 10) btn = 4'b0001;
        if (n == 12) btn = 4'b0000;
        if (n >= 20 && n < 25) begin
          pix_valid = 1'b1;
          hcnt = CW'(hcoord(mcol));
          vcnt = CW'(vcoord(mrow));
          sb.push_back('{1'b0, 1'b0, int'(hcnt), int'(vcnt)});
        end
        if (n == 25) pix_valid = 1'b0;
      end
      @(negedge CLK);
      n++;
    end
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    model_clear();
    RESET = 1'b0;
    repeat (3) @(negedge CLK);
    chk("rst cur_row", cur_row, 0);
    chk("rst cur_col", cur_col, 0);
    chk("rst cell_cnt", cell_cnt, 0);
    chk("rst pixel_cnt", pixel_cnt, 0);
    chk("rst on_valid", on_valid, 0);
    chk("rst on", on, 0);
    chk("rst busy", busy, 1);
    RESET = 1'b1;
    sweep(n, 1'b0);
    chk("reset_sweep_len", n, N);
    check_state("post_reset");

    wrap_en = 1'b0;
    set_pen(1'b1, 1'b0);
    repeat (3) begin press(4'b0001); @(negedge CLK); end
    chk("paint4 cell_cnt", cell_cnt, 4);
    chk("paint4 pixel_cnt", pixel_cnt, 100);
    chk("paint4 col", cur_col, 3);
    repeat (5) @(negedge CLK);
    chk("repaint cell_cnt", cell_cnt, 4);
    check_state("paint4");

    set_pen(1'b0, 1'b0);
    press(4'b1000);
    chk("clamp_down row", cur_row, 0);
    wrap_en = 1'b1;
    press(4'b1000);
    chk("wrap_down row", cur_row, 53);
    repeat (4) press(4'b0010);
    chk("wrap_left col", cur_col, 95);
    press(4'b0001);
    chk("wrap_right col", cur_col, 0);
    check_state("wrap");

    @(negedge CLK); btn = 4'b0101; model_move(4'b0101, wrap_en);
    repeat (4) @(negedge CLK);
    btn = '0;
    @(negedge CLK);
    chk("prio col", cur_col, 1);
    chk("prio row", cur_row, 53);
    check_state("prio_hold");
    press(4'b0010);
    press(4'b0010);

    set_pen(1'b1, 1'b0);
    set_pen(1'b0, 1'b0);
    check_state("corner_paint");
    pix(2, 2, 1'b1);
    pix(480, 2, 1'b1);
    pix(479, 269, 1'b1);
    pix(2, 270, 1'b1);
    pix(2, 2, 1'b0);
    pix_drain();
    render_batch(20);

    for (int it = 0; it < 150; it++) begin
      wrap_en = $urandom_range(0, 1) != 0;
      if ($urandom_range(0, 3) == 0) set_pen($urandom_range(0, 2) != 0, $urandom_range(0, 3) == 0);
      press(4'($urandom_range(1, 15)));
      check_state("rand");
      if (it % 25 == 24) render_batch(12);
    end
    set_pen(1'b1, 1'b0);
    set_pen(1'b0, 1'b0);

    @(negedge CLK); clear_req = 1'b1;
    @(negedge CLK); clear_req = 1'b0;
    chk("clear busy_next", busy, 1);
    model_clear();
    sweep(n, 1'b1);
    chk("clear_sweep_len", n, N);
    check_state("post_clear");
    render_batch(30);

    @(negedge CLK); clear_req = 1'b1;
    @(negedge CLK); clear_req = 0;
    repeat (100) @(negedge CLK);
    RESET = 1'b0;
    @(negedge CLK);
    RESET = 1'b1;
    mrow = 0; mcol = 0;
    sweep(n, 1'b0);
    chk("midclear_reset_len", n, N);
    check_state("post_midreset");

    repeat (4) @(negedge CLK);
    chk("sb_drain", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
